// File: rtl/alarm_clock_core.sv
// rtl/alarm_clock_core.sv - BCD time-of-day clock with alarm FSM and seven-segment outputs
module alarm_clock_core #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int ALARM_LEN_S = 30
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] time_in,
    input  logic [1:0] sel,
    input  logic       load_time,
    input  logic       load_alarm,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    input  logic       show_alarm,
    output logic [6:0] hex7,
    output logic [6:0] hex6,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       alarm_sound,
    output logic       load_err
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [7:0]    RING_LAST  = 8'(ALARM_LEN_S - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RINGING = 1'b1
    } state_t;

    // Time and alarm are packed BCD {hh, mm, ss, cc}
    logic [PW-1:0] r_presc;
    logic [31:0]   r_time;
    logic [31:0]   r_alarm;
    state_t        r_state;
    logic [7:0]    r_sec;
    logic          r_sound;
    logic          r_load_err;

    logic          w_tick;
    logic          w_valid;
    logic          w_lt_ok;
    logic          w_la_ok;
    logic          w_reject;
    logic          w_advance;
    logic          w_cc_wrap;
    logic          w_ss_wrap;
    logic          w_mm_wrap;
    logic          w_cc_roll;
    logic          w_match;
    logic [4:0]    w_base;
    logic [31:0]   w_time_inc;
    logic [31:0]   w_disp;

    // Operand must be two decimal digits and fit the range of the target field
    function automatic logic field_ok(input logic [7:0] v, input logic [1:0] f);
        logic digits_ok;
        digits_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
        case (f)
            2'd0:       field_ok = digits_ok;
            2'd1, 2'd2: field_ok = digits_ok && (v[7:4] <= 4'd5);
            default:    field_ok = digits_ok && (v <= 8'h23);
        endcase
    endfunction

    // Increment one BCD field, wrapping to 00 after its last legal value
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last) begin
            bcd_inc = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Active-low segment pattern for one digit; non-decimal nibbles blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Decode strobes, validate the operand and form the next time value with carries
    always_comb begin
        w_tick    = (r_presc == PRESC_LAST);
        w_valid   = field_ok(time_in, sel);
        w_lt_ok   = load_time & w_valid;
        // load_time has priority, so a simultaneous load_alarm is dropped silently
        w_la_ok   = ~load_time & load_alarm & w_valid;
        w_reject  = (load_time | load_alarm) & ~w_valid;
        // An accepted time load owns the cycle and suppresses the tick
        w_advance = w_tick & ~w_lt_ok;
        w_base    = {sel, 3'b000};

        w_cc_wrap = (r_time[7:0]   == 8'h99);
        w_ss_wrap = (r_time[15:8]  == 8'h59);
        w_mm_wrap = (r_time[23:16] == 8'h59);

        w_time_inc[7:0]   = bcd_inc(r_time[7:0], 8'h99);
        w_time_inc[15:8]  = w_cc_wrap ? bcd_inc(r_time[15:8], 8'h59) : r_time[15:8];
        w_time_inc[23:16] = (w_cc_wrap && w_ss_wrap) ?
                            bcd_inc(r_time[23:16], 8'h59) : r_time[23:16];
        w_time_inc[31:24] = (w_cc_wrap && w_ss_wrap && w_mm_wrap) ?
                            bcd_inc(r_time[31:24], 8'h23) : r_time[31:24];

        w_cc_roll = w_advance & w_cc_wrap;
        // Only a tick can create a match; the alarm cc field is ignored
        w_match   = alarm_en & w_advance & (w_time_inc[7:0] == 8'h00) &
                    (w_time_inc[31:8] == r_alarm[31:8]);
    end

    // Centisecond prescaler, restarted by an accepted time load
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_lt_ok || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Time register: field load wins over the tick advance
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_time <= '0;
        end else if (w_lt_ok) begin
            r_time[w_base +: 8] <= time_in;
        end else if (w_advance) begin
            r_time <= w_time_inc;
        end
    end

    // Alarm register, written one field at a time
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_alarm <= '0;
        end else if (w_la_ok) begin
            r_alarm[w_base +: 8] <= time_in;
        end
    end

    // One-cycle error pulse for a rejected load
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_reject;
        end
    end

    // Alarm FSM with ring-length seconds counter and registered sound output
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sec   <= 8'd0;
            r_sound <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_match) begin
                        r_state <= S_RINGING;
                        r_sec   <= 8'd0;
                        r_sound <= 1'b1;
                    end
                end
                S_RINGING: begin
                    // Further matches while ringing are ignored so the count runs on
                    if (!alarm_en || alarm_ack) begin
                        r_state <= S_IDLE;
                        r_sound <= 1'b0;
                    end else if (w_cc_roll) begin
                        r_sec <= r_sec + 8'd1;
                        if (r_sec == RING_LAST) begin
                            r_state <= S_IDLE;
                            r_sound <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sound <= 1'b0;
                end
            endcase
        end
    end

    // Seven-segment decode of whichever register is on display
    always_comb begin
        w_disp = show_alarm ? r_alarm : r_time;
        hex0   = seg7(w_disp[3:0]);
        hex1   = seg7(w_disp[7:4]);
        hex2   = seg7(w_disp[11:8]);
        hex3   = seg7(w_disp[15:12]);
        hex4   = seg7(w_disp[19:16]);
        hex5   = seg7(w_disp[23:20]);
        hex6   = seg7(w_disp[27:24]);
        hex7   = seg7(w_disp[31:28]);
    end

    assign alarm_sound = r_sound;
    assign load_err    = r_load_err;

endmodule

// File: doc/alarm_clock_core.md
ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLK_HZ, 50_000_000, CLOCK_50 frequency in Hz.
- TICK_HZ, 100, centisecond tick rate; CLK_HZ SHALL be an integer multiple of TICK_HZ.
- ALARM_LEN_S, 30, ring duration in seconds, 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- CLOCK_50 in 1: sole clock, rising edge.
- reset in 1: asynchronous, active-high.
- time_in in 8: two packed BCD digits, [7:4] tens and [3:0] units.
- sel in 2: field select; 0 = centiseconds, 1 = seconds, 2 = minutes, 3 = hours.
- load_time in 1: one-cycle strobe; writes time_in into the selected time field.
- load_alarm in 1: one-cycle strobe; writes time_in into the selected alarm field.
- alarm_en in 1: arms the alarm.
- alarm_ack in 1: one-cycle strobe; silences a ringing alarm.
- show_alarm in 1: when 1, the display shows the alarm registers instead of time.
- hex7..hex0 out 7 each: active-low seven-segment digits; hex7 = hours tens ... hex0 = centiseconds units.
- alarm_sound out 1: high while the alarm is ringing.
- load_err out 1: one-cycle pulse when a load is rejected.

Function
REQ-003 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and assert tick for the one cycle in which it wraps to 0.
REQ-004 Time SHALL be held as packed BCD {hh,mm,ss,cc}, 32 bits. Field ranges: hh 00-23, mm 00-59, ss 00-59, cc 00-99.
REQ-005 On tick, time SHALL advance by one centisecond with a BCD carry cascade: cc 99->00 carries into ss, ss 59->00 into mm, mm 59->00 into hh, and hh 23->00 with no further carry.
REQ-006 A load SHALL be accepted only if both digits are <= 9 and the value is within the selected field's range. A rejected load SHALL leave all registers unchanged and pulse load_err on the next cycle.
REQ-007 An accepted load SHALL update only the selected 8-bit field, and the update SHALL be visible on the cycle after the strobe.
REQ-008 An accepted load_time SHALL also clear the prescaler to 0.
REQ-009 If load_time and tick occur in the same cycle, the load SHALL win and no field SHALL advance in that cycle.
REQ-010 If load_time and load_alarm are asserted together, only load_time SHALL take effect and load_alarm SHALL be ignored without pulsing load_err.
REQ-011 The alarm FSM SHALL have two states, IDLE and RINGING.
REQ-012 The FSM SHALL go IDLE->RINGING when alarm_en=1 and a tick advances time to a value whose hh:mm:ss equals the alarm hh:mm:ss with cc=00. The alarm cc field is stored but SHALL NOT take part in the match.
REQ-013 Equality reached by reset or by load_time SHALL NOT trigger the alarm.
REQ-014 In RINGING, a seconds counter SHALL count ticks that roll cc 99->00.
REQ-015 The FSM SHALL go RINGING->IDLE when that counter reaches ALARM_LEN_S, or when alarm_ack=1, or when alarm_en=0, whichever comes first. The seconds counter SHALL be cleared on entry to RINGING.
REQ-016 alarm_sound SHALL be registered and equal 1 exactly in the cycles when the state is RINGING.
REQ-017 A new alarm match while already RINGING SHALL NOT restart the seconds counter.
REQ-018 Each hex digit SHALL be combinational from the displayed register, selected by show_alarm, with active-low patterns:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
- any other nibble = 1111111 (blank).
REQ-019 Time SHALL continue to advance while show_alarm=1.

Reset
REQ-020 While reset=1, these SHALL be held: time=00:00:00.00, alarm=00:00:00.00, prescaler=0, FSM=IDLE, seconds counter=0, alarm_sound=0, load_err=0, all hex outputs=1000000.
REQ-021 Reset asserted mid-ring SHALL drop alarm_sound immediately, asynchronously.
REQ-022 After reset releases, the first tick SHALL occur CLK_HZ/TICK_HZ cycles later.

Verification
Bench parameters: CLK_HZ=1000, TICK_HZ=100, ALARM_LEN_S=2, so one tick every 10 cycles.
REQ-023 Rollover: load 23:59:59.99 field by field, run one tick -> time reads 00:00:00.00 and all hex outputs = 1000000.
REQ-024 Load validation:
- sel=2 with time_in=0x60 -> load_err pulses for one cycle and minutes are unchanged.
- sel=3 with time_in=0x1A -> rejected the same way.
- sel=3 with time_in=0x23 -> accepted and hex7/hex6 show 2/3.
REQ-025 Alarm ring: alarm=00:00:01, alarm_en=1, time=00:00:00.99 -> after one tick alarm_sound=1, and it falls after exactly 2 s of ticks (200 ticks).
REQ-026 Alarm termination:
- alarm_ack pulsed 5 ticks into ringing -> alarm_sound=0 on the next cycle.
- Repeat with alarm_en dropped instead of ack -> same result.
REQ-027 No false trigger: reset with alarm=00:00:00 and alarm_en=1 -> alarm_sound stays 0. Then load_time to equal the alarm -> alarm_sound still stays 0.
REQ-028 Collision and reset cases:
- load_time in the same cycle as a tick -> only the loaded field changes and cc does not increment.
- reset asserted mid-ring -> alarm_sound=0 immediately.
